// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch/execute/commit sequencer driving PC strobes and the mem_req handshake.
// Define PC_FETCH_WDOG_EN to enable the mem_ack watchdog and the FAULT state.
module pc_fetch_ctrl #(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       mem_req,
  input  logic       mem_ack,
  input  logic       instr_len,
  output logic       ir_load,
  output logic       op_load,
  output logic       exec_start,
  input  logic       exec_done,
  input  logic       br_take,
  input  logic       br_rel,
  output logic       pc_read,
  output logic       pc_rdp1,
  output logic       pc_write,
  output logic       pc_offset,
  output logic       pc_inc,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, EXEC, WAIT, UPD, INC2, FAULT} state_t;
  state_t st, nxt;
  logic len_q, take_q, rel_q, wd_hit, fetch;
  assign fetch = st == FETCH0 || st == FETCH1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st     <= IDLE;
      len_q  <= 1'b0;
      take_q <= 1'b0;
      rel_q  <= 1'b0;
    end else begin
      st <= nxt;
      if (st == FETCH0 && mem_ack) len_q <= instr_len;
      if (st == WAIT && exec_done) begin
        take_q <= br_take;
        rel_q  <= br_rel;
      end
    end
  // A 2-word instruction only needs the second increment when it falls through.
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = run ? FETCH0 : IDLE;
      FETCH0:  nxt = mem_ack ? (instr_len ? FETCH1 : EXEC) : (wd_hit ? FAULT : FETCH0);
      FETCH1:  nxt = mem_ack ? EXEC : (wd_hit ? FAULT : FETCH1);
      EXEC:    nxt = WAIT;
      WAIT:    nxt = exec_done ? UPD : WAIT;
      UPD:     nxt = (!take_q && len_q) ? INC2 : (run ? FETCH0 : IDLE);
      INC2:    nxt = run ? FETCH0 : IDLE;
      default: nxt = FAULT;
    endcase
  end
  assign mem_req    = fetch;
  assign pc_read    = st == FETCH0;
  assign pc_rdp1    = st == FETCH1;
  assign ir_load    = st == FETCH0 && mem_ack;
  assign op_load    = st == FETCH1 && mem_ack;
  assign exec_start = st == EXEC;
  assign pc_offset  = st == UPD && take_q && rel_q;
  assign pc_write   = st == UPD && take_q && !rel_q;
  assign pc_inc     = (st == UPD && !take_q) || st == INC2;
  assign busy       = st != IDLE && st != FAULT;
  assign state      = st;
`ifdef PC_FETCH_WDOG_EN
  logic [CNT_W-1:0] cnt;
  // Counts ack-less fetch cycles; an ack on the limit cycle still wins.
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (fetch && !mem_ack) ? cnt + 1'b1 : '0;
  assign wd_hit = fetch && cnt == CNT_W'(ACK_TIMEOUT - 1);
  assign fault  = st == FAULT;
`else
  logic [CNT_W-1:0] unused_cfg;
  assign unused_cfg = CNT_W'(ACK_TIMEOUT);
  assign wd_hit     = 1'b0;
  assign fault      = 1'b0;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: scoreboard bench for pc_fetch_ctrl with a small PC model on the strobes.
module tb_pc_fetch_ctrl;
  logic clk = 0, reset = 0, run = 0, mem_ack = 0, instr_len = 0;
  logic exec_done = 0, br_take = 0, br_rel = 0;
  logic mem_req, ir_load, op_load, exec_start, pc_read, pc_rdp1, pc_write, pc_offset, pc_inc;
  logic busy, fault;
  logic [2:0] state;
  logic [13:0] outs;
  logic [15:0] din = 0, pc_m = 0, pc_init = 0;
  logic pc_load = 0;
  int n_chk = 0, n_fail = 0;
  int t_cyc = 0, t_inc = 0, t_wr = 0, t_off = 0, t_ir = 0, t_op = 0, viol = 0;
  typedef struct {logic [15:0] pc; int cyc, inc, wr, off, ir, op;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .run(run), .mem_req(mem_req), .mem_ack(mem_ack),
    .instr_len(instr_len), .ir_load(ir_load), .op_load(op_load), .exec_start(exec_start),
    .exec_done(exec_done), .br_take(br_take), .br_rel(br_rel), .pc_read(pc_read),
    .pc_rdp1(pc_rdp1), .pc_write(pc_write), .pc_offset(pc_offset), .pc_inc(pc_inc),
    .busy(busy), .fault(fault), .state(state)
  );

  assign outs = {mem_req, ir_load, op_load, exec_start, pc_read, pc_rdp1, pc_write,
                 pc_offset, pc_inc, busy, fault, state};

  always @(posedge clk)
    if (pc_load) pc_m <= pc_init;
    else if (pc_write) pc_m <= din;
    else if (pc_offset) pc_m <= pc_m + din;
    else if (pc_inc) pc_m <= pc_m + 16'd1;

  always @(negedge clk) begin
    t_cyc <= t_cyc + int'(busy);
    t_inc <= t_inc + int'(pc_inc);
    t_wr  <= t_wr + int'(pc_write);
    t_off <= t_off + int'(pc_offset);
    t_ir  <= t_ir + int'(ir_load);
    t_op  <= t_op + int'(op_load);
    if ($countones({pc_read, pc_rdp1, pc_write, pc_offset, pc_inc}) > 1 ||
        (mem_req && !(state == 3'd1 || state == 3'd2)))
      viol <= viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int dly);
    mem_ack = 0;
    repeat (dly) step();
    mem_ack = 1;
    step();
    mem_ack = 0;
  endtask

  task automatic start(input logic [15:0] pc);
    pc_init = pc;
    pc_load = 1;
    run = 1;
    step();
    pc_load = 0;
  endtask

  task automatic instr(input logic len, input int ack_dly, input int done_dly, input logic take,
                       input logic rel, input logic [15:0] d, input logic keep, input exp_t e);
    exp_t x;
    int c0, i0, w0, o0, r0, p0;
    sb.push_back(e);
    check("fetch0_entry", state, 3'd1);
    instr_len = len;
    br_take = take;
    br_rel = rel;
    din = d;
    c0 = t_cyc; i0 = t_inc; w0 = t_wr; o0 = t_off; r0 = t_ir; p0 = t_op;
    fetch(ack_dly);
    if (len) fetch(ack_dly);
    step();
    run = keep;
    repeat (done_dly) step();
    exec_done = 1;
    step();
    exec_done = 0;
    step();
    if (len && !take) step();
    x = sb.pop_front();
    check("pc", pc_m, x.pc);
    check("cycles", t_cyc - c0, x.cyc);
    check("inc_cnt", t_inc - i0, x.inc);
    check("write_cnt", t_wr - w0, x.wr);
    check("offset_cnt", t_off - o0, x.off);
    check("ir_cnt", t_ir - r0, x.ir);
    check("op_cnt", t_op - p0, x.op);
    check("boundary_state", state, keep ? 3'd1 : 3'd0);
    check("boundary_busy", busy, keep);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    step();
    step();
    check("reset_outs", outs, 0);
    reset = 1;
    step();
    step();
    check("idle_hold", state, 3'd0);
    // T1: async reset while in FETCH1
    run = 1;
    instr_len = 1;
    step();
    mem_ack = 1;
    step();
    mem_ack = 0;
    check("in_fetch1", state, 3'd2);
    #2 reset = 0;
    #1 check("reset_mid_outs", outs, 0);
    reset = 1;
    run = 0;
    repeat (3) step();
    check("idle_after_reset", state, 3'd0);
    check("idle_busy", busy, 0);
    // T2/T5: 1-word fall-through, run dropped during WAIT
    start(16'h0F0F);
    instr(0, 0, 0, 0, 0, 16'h0, 0, exp_t'{16'h0F10, 4, 1, 0, 0, 1, 0});
    // T3: 2-word, ack after 2 wait cycles
    start(16'h0F0F);
    instr(1, 2, 0, 0, 0, 16'h0, 0, exp_t'{16'h0F11, 10, 2, 0, 0, 1, 1});
    // T4: relative and absolute taken branches
    start(16'h0F0F);
    instr(0, 0, 0, 1, 1, 16'h0301, 0, exp_t'{16'h1210, 4, 0, 0, 1, 1, 0});
    start(16'h0F0F);
    instr(0, 0, 0, 1, 0, 16'h0200, 0, exp_t'{16'h0200, 4, 0, 1, 0, 1, 0});
    // Back-to-back instructions with run held
    start(16'h0100);
    instr(1, 0, 1, 0, 0, 16'h0, 1, exp_t'{16'h0102, 7, 2, 0, 0, 1, 1});
    instr(0, 1, 0, 1, 0, 16'h0040, 0, exp_t'{16'h0040, 5, 0, 1, 0, 1, 0});
    // T6: watchdog
    instr_len = 0;
    mem_ack = 0;
    run = 1;
    step();
`ifdef PC_FETCH_WDOG_EN
    begin
      int n = 0;
      for (int i = 0; i < 40 && !fault; i++) begin
        n += int'(mem_req);
        step();
      end
      check("wdog_cycles", n, 15);
      check("wdog_fault", fault, 1);
      check("wdog_state", state, 3'd7);
      repeat (3) step();
      check("fault_sticky", outs, {11'b0000_0000_001, 3'd7});
    end
    #2 reset = 0;
    #1 reset = 1;
    step();
    check("fault_cleared", fault, 0);
    repeat (14) step();
    mem_ack = 1;
    #1 check("ack_on_limit_ir", ir_load, 1);
    step();
    mem_ack = 0;
    check("ack_on_limit_state", state, 3'd3);
    check("ack_on_limit_fault", fault, 0);
`else
    repeat (100) step();
    check("no_wdog_fault", fault, 0);
    check("no_wdog_state", state, 3'd1);
`endif
    #2 reset = 0;
    run = 0;
    #1 reset = 1;
    step();
    check("final_idle", state, 3'd0);
    check("strobe_excl", viol, 0);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
